// File: rtl/alu_func_mux_pipe.sv
// Function-select multiplexer with a registered valid/ready output stage and a
// one-entry skid buffer; also reports zero/illegal-code flags and counts transfers.
module alu_func_mux_pipe #(
    parameter int WIDTH = 4,
    parameter int NSRC  = 8,
    parameter int SELW  = 3,
    parameter int CNTW  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       f,
    input  logic [NSRC*WIDTH-1:0] src,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_func,
    output logic                  out_zero,
    output logic                  out_err,
    output logic [CNTW-1:0]       xfer_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SELW-1:0]  func;
        logic             zero;
        logic             err;
    } entryT;

    // Encoding mirrors {out_valid, skid_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } stateT;

    stateT           state, nextState;
    entryT           selEntry, outEntry, skidEntry;
    logic            inReadyReg;
    logic            accept, drain;
    logic            loadOutFromSel, loadOutFromSkid, loadSkid;
    logic [CNTW-1:0] xferCntReg;

    assign accept = in_valid & inReadyReg;
    assign drain  = (state != EMPTY) & out_ready;

    always_comb begin
        logic [WIDTH-1:0] selData;
        logic             selHit;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        selData = '0;
        selHit  = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (f == SELW'(k)) begin
                selData = src[k*WIDTH +: WIDTH];
                selHit  = 1'b1;
            end
        end
        selEntry.data = selData;
        selEntry.func = f;
        selEntry.err  = ~selHit;
        selEntry.zero = selHit & (selData == '0);
    end

    always_comb begin
        nextState       = state;
        loadOutFromSel  = 1'b0;
        loadOutFromSkid = 1'b0;
        loadSkid        = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    nextState      = ONE;
                    loadOutFromSel = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    loadOutFromSel = 1'b1;
                end else if (accept) begin
                    nextState = FULL;
                    loadSkid  = 1'b1;
                end else if (drain) begin
                    nextState = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a drain can move the state.
                if (drain) begin
                    nextState       = ONE;
                    loadOutFromSkid = 1'b1;
                end
            end
            default: nextState = EMPTY;
        endcase
    end

    // in_ready is registered from the next skid state, so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state      <= EMPTY;
            inReadyReg <= 1'b0;
        end else begin
            state      <= nextState;
            inReadyReg <= ~nextState[0];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: data registers are reset too, because the output bus must read zero during reset.
        if (rst) begin
            outEntry   <= '0;
            skidEntry  <= '0;
            xferCntReg <= '0;
        end else begin
            if (loadOutFromSel) begin
                outEntry <= selEntry;
            end else if (loadOutFromSkid) begin
                outEntry <= skidEntry;
            end
            if (loadSkid) begin
                skidEntry <= selEntry;
            end
            if (drain) begin
                xferCntReg <= xferCntReg + 1'b1;
            end
        end
    end

    assign in_ready  = inReadyReg;
    assign out_valid = (state != EMPTY);
    assign out_data  = outEntry.data;
    assign out_func  = outEntry.func;
    assign out_zero  = outEntry.zero;
    assign out_err   = outEntry.err;
    assign xfer_cnt  = xferCntReg;

endmodule

// File: tb/tb_alu_func_mux_pipe.sv
// Directed bench: a full-range instance (NSRC=8, CNTW=8) and a reduced one
// (NSRC=6, CNTW=4) share stimulus; expected values are hand-computed.
module tb_alu_func_mux_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  f;
    logic [31:0] src;

    logic        aInReady, aOutValid, aOutZero, aOutErr;
    logic [3:0]  aOutData;
    logic [2:0]  aOutFunc;
    logic [7:0]  aXferCnt;

    logic        bInReady, bOutValid, bOutZero, bOutErr;
    logic [3:0]  bOutData;
    logic [2:0]  bOutFunc;
    logic [3:0]  bXferCnt;

    int tests = 0;
    int fails = 0;
    int expCnt = 0;

    always #5 clk = ~clk;

    alu_func_mux_pipe #(.WIDTH(4), .NSRC(8), .SELW(3), .CNTW(8)) dutA (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(aInReady),
        .f(f), .src(src), .out_valid(aOutValid), .out_ready(out_ready),
        .out_data(aOutData), .out_func(aOutFunc), .out_zero(aOutZero),
        .out_err(aOutErr), .xfer_cnt(aXferCnt)
    );

    alu_func_mux_pipe #(.WIDTH(4), .NSRC(6), .SELW(3), .CNTW(4)) dutB (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(bInReady),
        .f(f), .src(src[23:0]), .out_valid(bOutValid), .out_ready(out_ready),
        .out_data(bOutData), .out_func(bOutFunc), .out_zero(bOutZero),
        .out_err(bOutErr), .xfer_cnt(bXferCnt)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance past a rising edge; outputs are sampled and inputs driven 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setDefaultSrc();
        for (int k = 0; k < 8; k++) src[k*4 +: 4] = 4'(k + 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; f = '0;
        setDefaultSrc();

        // 1. Reset / idle
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_in_ready", aInReady, 0);
            check("rst_out_valid", aOutValid, 0);
            check("rst_out_data", aOutData, 0);
            check("rst_flags", {aOutFunc, aOutZero, aOutErr}, 0);
            check("rst_xfer_cnt", aXferCnt, 0);
        end
        rst = 1'b0;
        tick();
        check("release_in_ready", aInReady, 1);
        check("release_out_valid", aOutValid, 0);

        // 2. Basic select: f=4 selects slice 4 = 5
        f = 3'd4; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("basic_valid", aOutValid, 1);
        check("basic_data", aOutData, 5);
        check("basic_func", aOutFunc, 4);
        check("basic_zero", aOutZero, 0);
        check("basic_err", aOutErr, 0);
        tick();
        expCnt = 1;
        check("basic_cnt", aXferCnt, expCnt);
        check("basic_drained", aOutValid, 0);

        // 3. Back-pressure and skid
        out_ready = 1'b0; in_valid = 1'b1; f = 3'd1;
        tick();
        check("skid_first_data", aOutData, 2);
        check("skid_ready_one", aInReady, 1);
        f = 3'd2;
        tick();
        in_valid = 1'b0;
        check("skid_full_ready", aInReady, 0);
        check("skid_hold_data", aOutData, 2);
        src = '1;
        tick();
        check("skid_stable_data", aOutData, 2);
        check("skid_stable_valid", aOutValid, 1);
        check("skid_stable_ready", aInReady, 0);
        out_ready = 1'b1;
        tick();
        expCnt++;
        check("skid_second_data", aOutData, 3);
        check("skid_second_func", aOutFunc, 2);
        check("skid_second_valid", aOutValid, 1);
        check("skid_ready_back", aInReady, 1);
        check("skid_cnt1", aXferCnt, expCnt);
        tick();
        expCnt++;
        check("skid_empty", aOutValid, 0);
        check("skid_cnt2", aXferCnt, expCnt);
        setDefaultSrc();

        // 4. Streaming, f cycling 0..7; instance B flags codes 6 and 7
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            f = 3'(i % 8);
            tick();
            check("stream_valid", aOutValid, 1);
            check("stream_data", aOutData, (i % 8) + 1);
            check("stream_func", aOutFunc, i % 8);
            check("stream_ready", aInReady, 1);
            check("stream_b_err", bOutErr, ((i % 8) >= 6) ? 1 : 0);
            check("stream_b_data", bOutData, ((i % 8) >= 6) ? 0 : (i % 8) + 1);
        end
        in_valid = 1'b0;
        tick();
        expCnt += 16;
        check("stream_cnt", aXferCnt, expCnt);
        check("stream_b_cnt", bXferCnt, expCnt % 16);
        check("stream_empty", aOutValid, 0);

        // 5. Illegal code (only for B) and zero flag
        in_valid = 1'b1; f = 3'd7;
        tick();
        check("illegal_b_err", bOutErr, 1);
        check("illegal_b_data", bOutData, 0);
        check("illegal_b_zero", bOutZero, 0);
        check("illegal_b_func", bOutFunc, 7);
        check("legal_a_data", aOutData, 8);
        check("legal_a_err", aOutErr, 0);
        src[3:0] = 4'd0; f = 3'd0;
        tick();
        in_valid = 1'b0;
        check("zero_a_flag", aOutZero, 1);
        check("zero_a_err", aOutErr, 0);
        check("zero_b_flag", bOutZero, 1);
        check("zero_b_err", bOutErr, 0);
        check("zero_b_data", bOutData, 0);
        tick();
        expCnt += 2;
        check("flag_cnt", aXferCnt, expCnt);
        check("flag_b_cnt", bXferCnt, expCnt % 16);
        setDefaultSrc();

        // 6a. Reset while FULL discards both entries
        out_ready = 1'b0; in_valid = 1'b1; f = 3'd3;
        tick();
        f = 3'd5;
        tick();
        in_valid = 1'b0;
        check("full_before_rst", aInReady, 0);
        rst = 1'b1;
        tick();
        check("midrst_valid", aOutValid, 0);
        check("midrst_ready", aInReady, 0);
        check("midrst_data", aOutData, 0);
        check("midrst_cnt", aXferCnt, 0);
        rst = 1'b0; out_ready = 1'b1;
        tick();
        check("post_rst_valid", aOutValid, 0);
        check("post_rst_ready", aInReady, 1);
        tick();
        check("post_rst_no_stale", aOutValid, 0);
        check("post_rst_cnt", aXferCnt, 0);

        // 6b. 17 handshakes: B (CNTW=4) wraps to 1
        in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            f = 3'(i % 8);
            tick();
            check("wrap_data", aOutData, (i % 8) + 1);
        end
        in_valid = 1'b0;
        tick();
        check("wrap_a_cnt", aXferCnt, 17);
        check("wrap_b_cnt", bXferCnt, 1);
        check("wrap_empty", aOutValid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_func_mux_pipe.md
Name: alu_func_mux_pipe

Overview:
- Parametrised, pipelined successor to the ALU function-select multiplexer.
- Selects one of NSRC operation results by function code f and registers the selection onto a valid/ready output stage, with a 1-entry skid buffer so back-pressure never drops data.
- Sits between the ALU operation units and the result writeback.
- Adds a zero flag, an illegal-code flag and a transfer counter.

Parameters:
WIDTH, 4, bit width of each source result and of out_data
NSRC, 8, number of source results; legal range 2..2**SELW
SELW, 3, width of the function code
CNTW, 8, width of the transfer counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  function code and sources valid
in_ready  output  1  block can accept an input this cycle
f  input  SELW  function code; selects src slice f
src  input  NSRC*WIDTH  flat source bus; slice k = src[k*WIDTH +: WIDTH]
out_valid  output  1  output stage holds a result
out_ready  input  1  downstream accepts the result
out_data  output  WIDTH  selected result
out_func  output  SELW  function code that produced out_data
out_zero  output  1  out_data == 0 (and out_err == 0)
out_err  output  1  code f >= NSRC was issued; out_data forced 0
xfer_cnt  output  CNTW  count of completed output handshakes

Behaviour:
- Reset, sampled on clk while rst = 1:
  - out_valid = 0, out_data = 0, out_func = 0, out_zero = 0, out_err = 0, xfer_cnt = 0.
  - Skid buffer cleared.
  - in_ready = 0 while rst is high; 1 from the first cycle after rst falls.
  - Reset mid-operation discards the output stage and the skid entry. No partial result survives.
- Accept: in_valid & in_ready on a rising edge.
  - The block captures {selected slice, f, err, zero} from a combinational selection of the current f/src.
  - A source bus that changes afterwards does not affect the captured result.
- Illegal code (f >= NSRC): accepted normally, with data = 0, err = 1, zero = 0.
- Output handshake: a transfer completes on out_valid & out_ready.
  - out_data, out_func, out_zero and out_err are stable while out_valid = 1 and out_ready = 0.
- Latency: accept in cycle N gives out_valid = 1 in cycle N+1 if the output stage was empty or drained in cycle N.
- Throughput: 1 result per cycle while out_ready is held high.
- in_ready = NOT skid_valid. It is a register output with no combinational path from out_ready.
- State is defined by {out_valid, skid_valid}. Three legal states: EMPTY (0,0), ONE (1,0), FULL (1,1).
  - EMPTY: accept goes to ONE (output loaded). Otherwise stay.
  - ONE:
    - accept and drain: output reloads, stay ONE.
    - accept without drain: new entry goes to skid, go FULL.
    - drain without accept: go EMPTY.
    - neither: stay.
  - FULL: in_ready = 0, so no accept. Drain moves the skid entry into the output and goes to ONE. Otherwise stay.
- Ordering is strictly FIFO; the skid entry is never overtaken.
- xfer_cnt increments by 1 on each output handshake and wraps from 2**CNTW-1 to 0 without a flag.
- Simultaneous accept and drain in the same cycle is legal and must not lose or duplicate data.

Test Plan:
1. Reset/idle: WIDTH=4, NSRC=8; hold rst 3 cycles -> all outputs 0 and in_ready=0 during reset; in_ready=1 the cycle after release.
2. Basic select: src slices k = k+1 (slice 4 = 5); f=4, in_valid 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=5, out_func=4, out_zero=0; xfer_cnt=1.
3. Back-pressure/skid: out_ready=0; issue f=1 (data 2) then f=2 (data 3) -> after 2nd accept in_ready=0, out_data holds 2. Raise out_ready -> outputs 2 then 3 in consecutive cycles, in_ready returns to 1, xfer_cnt=2.
4. Streaming: out_ready=1, in_valid=1 for 16 cycles with f cycling 0..7 -> 16 results in order, one per cycle, no gaps after the first, xfer_cnt=16.
5. Illegal code and zero flag: NSRC=6, f=7 -> out_err=1, out_data=0, out_zero=0. Then slice 0 = 0 with f=0 -> out_zero=1, out_err=0.
6. Reset mid-operation and counter wrap:
   - Reset while in state FULL -> out_valid=0 next cycle, no stale result appears after release.
   - CNTW=4 with 17 handshakes -> xfer_cnt=1.
